// File: rtl/serial_logic_unit_pkg.sv
// serial_logic_unit_pkg: shared opcode and state encodings for the serial logic unit
package serial_logic_unit_pkg;
  typedef enum logic [1:0] {OP_AND = 2'b00, OP_NAND = 2'b01, OP_OR = 2'b10, OP_XOR = 2'b11} op_t;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_DONE = 2'b10} state_t;
endpackage

// File: rtl/serial_logic_unit_cell.sv
// serial_logic_unit_cell: 2-input gate primitives and the 1-bit logic cell built only from them
module and_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

module NAND_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

module bit_logic_cell
  import serial_logic_unit_pkg::*;
(
  output logic       out,
  input  logic       a,
  input  logic       b,
  input  logic [1:0] op
);
  logic and_ab, nand_ab, na, nb, or_ab, xor_ab;
  and_gate  u_and  (.a(a),     .b(b),       .y(and_ab));
  NAND_gate u_nand (.a(a),     .b(b),       .y(nand_ab));
  NAND_gate u_na   (.a(a),     .b(a),       .y(na));
  NAND_gate u_nb   (.a(b),     .b(b),       .y(nb));
  NAND_gate u_or   (.a(na),    .b(nb),      .y(or_ab));
  and_gate  u_xor  (.a(or_ab), .b(nand_ab), .y(xor_ab));
  always_comb
    out = (op == OP_AND)  ? and_ab  :
          (op == OP_NAND) ? nand_ab :
          (op == OP_OR)   ? or_ab   : xor_ab;
endmodule

// File: rtl/serial_logic_unit.sv
// serial_logic_unit: bit-serial AND/NAND/OR/XOR of two WIDTH-bit operands, one bit per clock
module serial_logic_unit
  import serial_logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_t           state, nxt;
  logic [WIDTH-1:0] sa, sb, work, nwork;
  logic [1:0]       sop;
  logic [CW-1:0]    cnt;
  logic             bit_out, accept, last;
  bit_logic_cell u_cell (.out(bit_out), .a(sa[0]), .b(sb[0]), .op(sop));
  always_comb begin
    accept = start && (state != S_RUN);
    last   = cnt == CW'(WIDTH - 1);
    nwork  = {bit_out, work[WIDTH-1:1]};
    nxt    = accept ? S_RUN :
             (state == S_RUN) ? (last ? S_DONE : S_RUN) : S_IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      zero   <= 1'b0;
      cnt    <= '0;
      sa     <= '0;
      sb     <= '0;
      sop    <= 2'b00;
      work   <= '0;
    end else begin
      state <= nxt;
      busy  <= nxt == S_RUN;
      done  <= nxt == S_DONE;
      if (accept) begin
        sa   <= a;
        sb   <= b;
        sop  <= op;
        cnt  <= '0;
        work <= '0;
      end else if (state == S_RUN) begin
        work <= nwork;
        sa   <= sa >> 1;
        sb   <= sb >> 1;
        cnt  <= cnt + CW'(1);
        if (last) begin
          result <= nwork;
          zero   <= nwork == '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_logic_unit.sv
// tb_serial_logic_unit: directed checks of latency, results, flags, back-to-back, reset and hold
module tb_serial_logic_unit;
  logic       clk = 1'b0, rst, start;
  logic [1:0] op;
  logic [7:0] a, b, result;
  logic       busy, done, zero;
  int         checks = 0, errors = 0;

  serial_logic_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .result(result), .busy(busy), .done(done), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is high (or budget exhausted).
  task automatic do_op(input string tag, input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] exp, input int inj);
    int n = 0, nbusy = 0, both = 0;
    start = 1'b1; op = o; a = x; b = y;
    do begin
      @(negedge clk);
      n++;
      nbusy += int'(busy);
      both  += int'(busy && done);
      start = (n == inj);
      if (start) begin a = 8'h00; b = 8'hFF; op = 2'b10; end
    end while (!done && n < 30);
    start = 1'b0;
    chk({tag, "_edges"}, n, 9);
    chk({tag, "_busy_cycles"}, nbusy, 8);
    chk({tag, "_busy_done_overlap"}, both, 0);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_result"}, result, exp);
    chk({tag, "_zero"}, zero, exp == 8'h00);
  endtask

  task automatic idle_chk(input string tag, input logic [7:0] exp);
    @(negedge clk);
    chk({tag, "_done_low"}, done, 0);
    chk({tag, "_busy_low"}, busy, 0);
    chk({tag, "_result_hold"}, result, exp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; a = 8'h00; b = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_zero", zero, 0);
    rst = 1'b0;
    @(negedge clk);
    do_op("and_a5_3c", 2'b00, 8'hA5, 8'h3C, 8'h24, 0);
    for (int i = 0; i < 20; i++) idle_chk("idle_hold", 8'h24);
    do_op("nand_ff_ff", 2'b01, 8'hFF, 8'hFF, 8'h00, 0);
    idle_chk("after_nand", 8'h00);
    do_op("or_0f_f0", 2'b10, 8'h0F, 8'hF0, 8'hFF, 0);
    idle_chk("after_or", 8'hFF);
    do_op("xor_aa_ignore_start", 2'b11, 8'hAA, 8'hAA, 8'h00, 3);
    idle_chk("after_xor", 8'h00);
    do_op("b2b_xor", 2'b11, 8'h0F, 8'h3C, 8'h33, 0);
    do_op("b2b_and", 2'b00, 8'hF0, 8'hFF, 8'hF0, 0);
    idle_chk("after_b2b", 8'hF0);
    start = 1'b1; op = 2'b00; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_result", result, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_zero", zero, 0);
    @(negedge clk);
    rst = 1'b0;
    idle_chk("post_reset_idle", 8'h00);
    do_op("post_reset_xor", 2'b11, 8'h0F, 8'h3C, 8'h33, 0);
    idle_chk("post_reset_hold", 8'h33);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
